// File: rtl/speed_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_seq_pkg
//  Description : Shared state encoding, default widths and helpers for the
//                speed sequencer (button debounce + soft-ramp controller).
//  Revision    : 1.0  initial release
// ============================================================================
package speed_seq_pkg;

  // Default width of the target and speed codes
  localparam int SPEED_W_DEF = 3;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RAMP = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_STOP = 2'd3;

  // Largest code representable in a w-bit speed field
  function automatic int speed_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, stability-count debouncer and
//                rising-edge pulse for one raw push-button. The pulse is
//                asserted in the cycle where the debounced level is about to
//                go high, so the consumer updates on the same edge as the
//                debounced level itself.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Synced level has disagreed with the stable level for DEB_CYCLES samples
  assign accept = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
  assign rise   = accept && sync2_q;

  // Synchronizer chain and stability counter next-state
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Register synchronizer, debounced level and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/speed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : speed_sequencer
//  Description : Debounces up/down buttons into a saturating target code and
//                soft-ramps the delivered speed code toward it, one LSB per
//                RAMP_DIV cycles. Drives the PWM stage speed and enable.
//                Build option SPEED_SEQ_INSTANT_EN: no ramp prescaler, speed
//                jumps straight to its goal and ramping stays low.
//  Revision    : 1.0  initial release
// ============================================================================
module speed_sequencer
  import speed_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int RAMP_DIV   = 256,
  parameter int SPEED_W    = SPEED_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               btn_up,
  input  logic               btn_dn,
  output logic [SPEED_W-1:0] speed,
  output logic               pwm_en,
  output logic               ramping,
  output logic [SPEED_W-1:0] target
);

  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(speed_max(SPEED_W));

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic               pwm_en_q, pwm_en_d;
  logic               ramping_q, ramping_d;
  logic [SPEED_W-1:0] goal;
  logic [SPEED_W-1:0] next_speed;
  logic               up_rise, dn_rise;
  logic               in_motion;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_up),
    .rise    (up_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_dn),
    .rise    (dn_rise)
  );

  // STOP always heads for zero; otherwise follow the live target
  assign goal      = (state_q == ST_STOP) ? '0 : target_q;
  assign in_motion = (state_q == ST_RAMP) || (state_q == ST_STOP);

  // Saturating target update; simultaneous presses cancel
  always_comb begin
    target_d = target_q;
    if (up_rise && !dn_rise && (target_q != SPEED_MAX)) begin
      target_d = target_q + 1'b1;
    end else if (dn_rise && !up_rise && (target_q != '0)) begin
      target_d = target_q - 1'b1;
    end
  end

`ifdef SPEED_SEQ_INSTANT_EN
  // Instant mode: speed jumps straight to the goal
  always_comb begin
    next_speed = goal;
    ramping_d  = 1'b0;
  end
`else
  localparam int PRE_W = $clog2(RAMP_DIV);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;

  assign tick = (presc_q == PRE_W'(RAMP_DIV - 1));

  // One LSB toward the goal per prescaler tick; ramping flag from current state
  always_comb begin
    next_speed = speed_q;
    if (tick) begin
      next_speed = (speed_q < goal) ? speed_q + 1'b1 : speed_q - 1'b1;
    end
    ramping_d = in_motion && (speed_q != goal);
  end

  // Prescaler runs only while moving and restarts on every state change
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (!in_motion || (state_d != state_q) || tick) begin
      presc_d = '0;
    end
  end

  // Register the ramp prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  // Sequencer next-state: run low wins over any target change
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    pwm_en_d = pwm_en_q;
    case (state_q)
      ST_IDLE: begin
        speed_d  = '0;
        pwm_en_d = 1'b0;
        if (run) begin
          state_d  = ST_RAMP;
          pwm_en_d = 1'b1;
        end
      end
      ST_RAMP: begin
        if (!run) begin
          state_d = ST_STOP;
        end else if (speed_q == goal) begin
          state_d = ST_HOLD;
        end else begin
          speed_d = next_speed;
        end
      end
      ST_HOLD: begin
        if (!run) begin
          state_d = ST_STOP;
        end else if (target_q != speed_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_STOP: begin
        if (run) begin
          state_d = ST_RAMP;
        end else if (speed_q == '0) begin
          state_d  = ST_IDLE;
          pwm_en_d = 1'b0;
        end else begin
          speed_d = next_speed;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register sequencer state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      speed_q   <= '0;
      target_q  <= '0;
      pwm_en_q  <= 1'b0;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      target_q  <= target_d;
      pwm_en_q  <= pwm_en_d;
      ramping_q <= ramping_d;
    end
  end

  assign speed   = speed_q;
  assign pwm_en  = pwm_en_q;
  assign ramping = ramping_q;
  assign target  = target_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speed_sequencer
//  Description : Self-checking bench for speed_sequencer (DEB_CYCLES=4,
//                RAMP_DIV=8). Directed steps plus randomized button/run
//                traffic compared against a behavioural model.
//                Honours SPEED_SEQ_INSTANT_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_speed_sequencer;

  localparam int DEB  = 4;
  localparam int RDIV = 8;
  localparam int SMAX = 7;
`ifdef SPEED_SEQ_INSTANT_EN
  localparam bit INSTANT = 1'b1;
`else
  localparam bit INSTANT = 1'b0;
`endif

  // Model operating modes
  localparam int MD_IDLE = 0;
  localparam int MD_RAMP = 1;
  localparam int MD_HOLD = 2;
  localparam int MD_STOP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [2:0] speed;
  logic       pwm_en;
  logic       ramping;
  logic [2:0] target;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  speed_sequencer #(.DEB_CYCLES(DEB), .RAMP_DIV(RDIV), .SPEED_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .speed   (speed),
    .pwm_en  (pwm_en),
    .ramping (ramping),
    .target  (target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_s1[2], m_s2[2], m_st[2], m_len[2], m_ev[2], m_raw[2];
  int m_target, m_speed, m_pwm, m_ramp, m_mode, m_next, m_ph, m_goal;
  bit m_tick;

  task model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_st[b] = 0; m_len[b] = 0; m_ev[b] = 0;
    end
    m_target = 0; m_speed = 0; m_pwm = 0; m_ramp = 0;
    m_mode = MD_IDLE; m_ph = 0;
  endtask

  task model_step();
    m_raw[0] = int'(btn_up);
    m_raw[1] = int'(btn_dn);
    // a button level is accepted after DEB consecutive disagreeing synced samples
    for (int b = 0; b < 2; b++) begin
      m_ev[b] = 0;
      if (m_s2[b] != m_st[b]) begin
        m_len[b]++;
        if (m_len[b] == DEB) begin
          m_st[b] = m_s2[b];
          m_len[b] = 0;
          m_ev[b] = m_st[b];
        end
      end else begin
        m_len[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = m_raw[b];
    end
    m_goal = (m_mode == MD_STOP) ? 0 : m_target;
    m_ramp = (!INSTANT && (m_mode == MD_RAMP || m_mode == MD_STOP) && m_speed != m_goal) ? 1 : 0;
    m_tick = ((m_ph % RDIV) == RDIV - 1);
    m_next = m_mode;
    case (m_mode)
      MD_IDLE: if (run) begin m_next = MD_RAMP; m_pwm = 1; end
      MD_RAMP: begin
        if (!run) m_next = MD_STOP;
        else if (m_speed == m_goal) m_next = MD_HOLD;
        else if (INSTANT) m_speed = m_goal;
        else if (m_tick) m_speed += (m_goal > m_speed) ? 1 : -1;
      end
      MD_HOLD: begin
        if (!run) m_next = MD_STOP;
        else if (m_target != m_speed) m_next = MD_RAMP;
      end
      default: begin
        if (run) m_next = MD_RAMP;
        else if (m_speed == 0) begin m_next = MD_IDLE; m_pwm = 0; end
        else if (INSTANT) m_speed = 0;
        else if (m_tick) m_speed -= 1;
      end
    endcase
    m_ph = (m_next == m_mode) ? m_ph + 1 : 0;
    m_mode = m_next;
    m_target = m_target + m_ev[0] - m_ev[1];
    if (m_target > SMAX) m_target = SMAX;
    if (m_target < 0) m_target = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_speed", speed, m_speed);
      check("model_pwm_en", pwm_en, m_pwm);
      check("model_ramping", ramping, m_ramp);
      check("model_target", target, m_target);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u;
    btn_dn = d;
    cyc(8);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    cyc(8);
  endtask

  initial begin
    // reset state with btn_up held through reset
    btn_up = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    check("rst_speed", speed, 0);
    check("rst_pwm_en", pwm_en, 0);
    check("rst_ramping", ramping, 0);
    check("rst_target", target, 0);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      check("deb_latency_target", target, (i == 6) ? 1 : 0);
    end
    btn_up = 1'b0;
    cyc(10);

    // bouncing button then stable high: one increment only
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      cyc(1);
    end
    check("bounce_no_inc", target, 0);
    btn_up = 1'b1;
    cyc(10);
    check("bounce_one_inc", target, 1);
    btn_up = 1'b0;
    cyc(10);

    // saturation, decrements and cancelling simultaneous press
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
    check("sat_max", target, 7);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    check("three_down", target, 4);
    press(1'b1, 1'b1);
    check("both_press", target, 4);

`ifndef SPEED_SEQ_INSTANT_EN
    // ramp from 0 to target 3
    press(1'b0, 1'b1);
    check("target_3", target, 3);
    run = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      cyc(1);
      check("ramp_up_speed", speed, (k >= 24) ? 3 : k / 8);
      check("ramp_up_pwm_en", pwm_en, 1);
      check("ramp_up_ramping", ramping, (k >= 1 && k <= 24) ? 1 : 0);
    end

    // full stop from HOLD at 3
    run = 1'b0;
    for (int j = 0; j <= 25; j++) begin
      cyc(1);
      check("stop_speed", speed, (j >= 24) ? 0 : 3 - j / 8);
      check("stop_pwm_en", pwm_en, (j <= 24) ? 1 : 0);
    end

    // ramp up again, then stop and re-run at speed 1
    run = 1'b1;
    cyc(30);
    check("reramp_speed", speed, 3);
    run = 1'b0;
    cyc(17);
    check("stop_at_1", speed, 1);
    run = 1'b1;
    for (int j = 0; j < 40; j++) begin
      cyc(1);
      check("rerun_pwm_en", pwm_en, 1);
    end
    check("rerun_speed", speed, 3);
    run = 1'b0;
    cyc(30);

    // asynchronous reset mid-ramp at speed 2
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 40 && speed != 3'd2; i++) cyc(1);
    check("mid_speed", speed, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_speed", speed, 0);
    check("async_pwm_en", pwm_en, 0);
    check("async_target", target, 0);
    cyc(2);
    run = 1'b0;
    #2 rst_n = 1'b1;
    cyc(2);
`else
    // instant mode: target 5 reached one cycle after RAMP entry
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    check("inst_target", target, 5);
    run = 1'b1;
    cyc(1);
    check("inst_entry_speed", speed, 0);
    check("inst_entry_pwm_en", pwm_en, 1);
    cyc(1);
    check("inst_speed", speed, 5);
    check("inst_ramping", ramping, 0);
    run = 1'b0;
    cyc(5);
`endif

    // randomized button and run traffic against the model
    for (int s = 0; s < 80; s++) begin
      btn_up = ($urandom_range(0, 2) == 0);
      btn_dn = ($urandom_range(0, 2) == 0);
      run    = ($urandom_range(0, 9) < 7);
      cyc($urandom_range(1, 30));
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    run = 1'b0;
    cyc(40);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
